// File: rtl/bp_pkg.sv
// Shared constants and types for the dynamic branch predictor.
package bp_pkg;

    // 2-bit saturating counter states
    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    // PC mux select encodings
    localparam logic [1:0] PCSEL_SEQ   = 2'b00;
    localparam logic [1:0] PCSEL_PRED  = 2'b01;
    localparam logic [1:0] PCSEL_RECOV = 2'b10;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } bp_state_e;

    // Saturating step of a 2-bit counter toward the resolved direction
    function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
        logic [1:0] res;
        res = ctr;
        if (taken && ctr != ST)
            res = ctr + 2'd1;
        else if (!taken && ctr != SNT)
            res = ctr - 2'd1;
        return res;
    endfunction

endpackage

// File: rtl/bp_bht.sv
// Branch history table: 2-bit counters, one combinational read port,
// one synchronous saturating update port, synchronous active-low reset.
module bp_bht
    import bp_pkg::*;
#(
    parameter int unsigned ENTRIES  = 64,
    parameter int unsigned IDX_W    = $clog2(ENTRIES),
    parameter logic [1:0]  CTR_INIT = WNT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [1:0]       rd_ctr,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken
);

    logic [1:0] ctr [ENTRIES];

    // Read returns the pre-update value; same-index writes are not bypassed
    always_comb rd_ctr = ctr[rd_idx];

    // Reset every counter, otherwise apply the resolved outcome
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < ENTRIES; i++)
                ctr[i] <= CTR_INIT;
        end else if (wr_en) begin
            ctr[wr_idx] <= sat_update(ctr[wr_idx], wr_taken);
        end
    end

endmodule

// File: rtl/branch_predict_ctrl.sv
// Dynamic branch-prediction controller: predict in IF, resolve in EX,
// flush and redirect on mispredict. Optional gshare indexing via BP_GSHARE_EN.
module branch_predict_ctrl
    import bp_pkg::*;
#(
    parameter int unsigned BHT_ENTRIES = 64,
    parameter int unsigned IDX_W       = $clog2(BHT_ENTRIES),
    parameter logic [1:0]  CTR_INIT    = 2'b01
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [31:0]      IF_PC,
    input  logic             IF_Branch,
    input  logic [31:0]      IF_BrTarget,
    input  logic             Stall,
    output logic             PredTaken,
    output logic [IDX_W-1:0] PredIdx,
    input  logic             EX_Branch,
    input  logic             EX_Taken,
    input  logic             EX_PredTaken,
    input  logic [IDX_W-1:0] EX_Idx,
    input  logic [31:0]      EX_PC,
    input  logic [31:0]      EX_Target,
    output logic [1:0]       PCSel,
    output logic [31:0]      RecoverPC,
    output logic             Flush,
    output logic [15:0]      PerfBr,
    output logic [15:0]      PerfMisp
);

    bp_state_e        state, next_state;
    logic             run, resolve, mispredict;
    logic [IDX_W-1:0] fetch_idx;
    logic [1:0]       rd_ctr;
    logic             unused_pc_bits;

    // The target itself is muxed in the datapath; only the select is produced here
    assign unused_pc_bits = ^{IF_PC[31:IDX_W+2], IF_PC[1:0], IF_BrTarget};

    assign run        = (state == RUN) && Rst;
    assign resolve    = EX_Branch && run;
    assign mispredict = resolve && (EX_Taken != EX_PredTaken);
    assign RecoverPC  = EX_Taken ? EX_Target : EX_PC + 32'd4;

`ifdef BP_GSHARE_EN
    logic [IDX_W-1:0] ghr;

    // Global history shifts in every resolved outcome
    always_ff @(posedge Clk) begin
        if (!Rst)
            ghr <= '0;
        else if (resolve)
            ghr <= {ghr[IDX_W-2:0], EX_Taken};
    end

    assign fetch_idx = IF_PC[IDX_W+1:2] ^ ghr;
`else
    assign fetch_idx = IF_PC[IDX_W+1:2];
`endif

    bp_bht #(
        .ENTRIES  (BHT_ENTRIES),
        .IDX_W    (IDX_W),
        .CTR_INIT (CTR_INIT)
    ) u_bht (
        .clk      (Clk),
        .rst      (Rst),
        .rd_idx   (fetch_idx),
        .rd_ctr   (rd_ctr),
        .wr_en    (resolve),
        .wr_idx   (EX_Idx),
        .wr_taken (EX_Taken)
    );

    // State register
    always_ff @(posedge Clk) begin
        if (!Rst)
            state <= RUN;
        else
            state <= next_state;
    end

    // Next state and PC steering; mispredict outranks stall and prediction
    always_comb begin
        next_state = state;
        PredTaken  = 1'b0;
        PredIdx    = '0;
        Flush      = 1'b0;
        PCSel      = PCSEL_SEQ;
        if (Rst)
            PredIdx = fetch_idx;
        case (state)
            RUN: begin
                if (Rst) begin
                    PredTaken = IF_Branch && rd_ctr[1] && !Stall;
                    if (mispredict) begin
                        Flush      = 1'b1;
                        PCSel      = PCSEL_RECOV;
                        next_state = FLUSH;
                    end else if (PredTaken) begin
                        PCSel = PCSEL_PRED;
                    end
                end
            end
            FLUSH: next_state = RUN;
            default: next_state = RUN;
        endcase
    end

    // Saturating performance counters
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            PerfBr   <= '0;
            PerfMisp <= '0;
        end else begin
            if (resolve && PerfBr != '1)
                PerfBr <= PerfBr + 16'd1;
            if (mispredict && PerfMisp != '1)
                PerfMisp <= PerfMisp + 16'd1;
        end
    end

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Directed self-checking bench for branch_predict_ctrl.
module tb_branch_predict_ctrl;
    import bp_pkg::*;

    logic        Clk;
    logic        Rst;
    logic [31:0] IF_PC;
    logic        IF_Branch;
    logic [31:0] IF_BrTarget;
    logic        Stall;
    logic        PredTaken;
    logic [5:0]  PredIdx;
    logic        EX_Branch;
    logic        EX_Taken;
    logic        EX_PredTaken;
    logic [5:0]  EX_Idx;
    logic [31:0] EX_PC;
    logic [31:0] EX_Target;
    logic [1:0]  PCSel;
    logic [31:0] RecoverPC;
    logic        Flush;
    logic [15:0] PerfBr;
    logic [15:0] PerfMisp;

    int n_cmp = 0;
    int n_err = 0;

    branch_predict_ctrl #(
        .BHT_ENTRIES (64),
        .CTR_INIT    (2'b01)
    ) dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .IF_PC        (IF_PC),
        .IF_Branch    (IF_Branch),
        .IF_BrTarget  (IF_BrTarget),
        .Stall        (Stall),
        .PredTaken    (PredTaken),
        .PredIdx      (PredIdx),
        .EX_Branch    (EX_Branch),
        .EX_Taken     (EX_Taken),
        .EX_PredTaken (EX_PredTaken),
        .EX_Idx       (EX_Idx),
        .EX_PC        (EX_PC),
        .EX_Target    (EX_Target),
        .PCSel        (PCSel),
        .RecoverPC    (RecoverPC),
        .Flush        (Flush),
        .PerfBr       (PerfBr),
        .PerfMisp     (PerfMisp)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change 1 ns after the rising edge
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic resolve(input logic [5:0] idx, input logic taken, input logic pred);
        EX_Branch    = 1'b1;
        EX_Idx       = idx;
        EX_Taken     = taken;
        EX_PredTaken = pred;
        step();
        EX_Branch    = 1'b0;
    endtask

    initial begin
        Rst = 1'b0; IF_PC = '0; IF_Branch = 1'b0; IF_BrTarget = '0; Stall = 1'b0;
        EX_Branch = 1'b0; EX_Taken = 1'b0; EX_PredTaken = 1'b0; EX_Idx = '0;
        EX_PC = '0; EX_Target = '0;
        step(); step();

        // History-indexing scenario: T, NT, T then fetch 0x40
        Rst = 1'b1;
        resolve(6'd0, 1'b1, 1'b1);
        resolve(6'd0, 1'b0, 1'b0);
        resolve(6'd0, 1'b1, 1'b1);
        IF_PC = 32'h40;
        #1;
`ifdef BP_GSHARE_EN
        chk("gshare_idx", 32'(PredIdx), 32'd21);
`else
        chk("bimodal_idx", 32'(PredIdx), 32'd16);
`endif

        // Reset held 2 cycles with a would-be mispredict on EX
        Rst = 1'b0; IF_Branch = 1'b1; IF_PC = 32'h40;
        EX_Branch = 1'b1; EX_Taken = 1'b1; EX_PredTaken = 1'b0; EX_Target = 32'h300;
        #1;
        chk("rst_pred", 32'(PredTaken), 32'd0);
        chk("rst_flush", 32'(Flush), 32'd0);
        chk("rst_pcsel", 32'(PCSel), 32'd0);
        chk("rst_idx", 32'(PredIdx), 32'd0);
        chk("rst_recov", RecoverPC, 32'h300);
        step(); step();
        Rst = 1'b1; EX_Branch = 1'b0;
        #1;
        chk("rst_ctr16", 32'(dut.u_bht.ctr[16]), 32'd1);
        chk("rst_ctr0", 32'(dut.u_bht.ctr[0]), 32'd1);
        chk("rst_state", 32'(dut.state), 32'(RUN));
        chk("rst_perfbr", 32'(PerfBr), 32'd0);
        chk("rst_perfmisp", 32'(PerfMisp), 32'd0);
        chk("weak_nt_pred", 32'(PredTaken), 32'd0);
        chk("weak_nt_idx", 32'(PredIdx), 32'd16);

        // Training: branch at 0x40 resolves taken twice
        IF_Branch = 1'b0;
        resolve(6'd16, 1'b1, 1'b1);
        chk("train_ctr_a", 32'(dut.u_bht.ctr[16]), 32'd2);
        resolve(6'd16, 1'b1, 1'b1);
        chk("train_ctr_b", 32'(dut.u_bht.ctr[16]), 32'd3);
        chk("train_perfbr", 32'(PerfBr), 32'd2);
        IF_Branch = 1'b1; IF_BrTarget = 32'h200;
        #1;
        chk("train_pred", 32'(PredTaken), 32'd1);
        chk("train_pcsel", 32'(PCSel), 32'd1);
        chk("train_flush", 32'(Flush), 32'd0);
        Stall = 1'b1;
        #1;
        chk("stall_pred", 32'(PredTaken), 32'd0);
        chk("stall_pcsel", 32'(PCSel), 32'd0);

        // Mispredict under stall with a taken prediction in IF
        EX_Branch = 1'b1; EX_Idx = 6'd3; EX_PC = 32'h80;
        EX_PredTaken = 1'b0; EX_Taken = 1'b1; EX_Target = 32'h100;
        #1;
        chk("misp_flush", 32'(Flush), 32'd1);
        chk("misp_pcsel", 32'(PCSel), 32'd2);
        chk("misp_recov", RecoverPC, 32'h100);
        Stall = 1'b0;
        #1;
        chk("misp_pcsel_nostall", 32'(PCSel), 32'd2);
        step();
        chk("flush_state", 32'(dut.state), 32'(FLUSH));
        chk("flush_flush", 32'(Flush), 32'd0);
        chk("flush_pcsel", 32'(PCSel), 32'd0);
        chk("flush_pred", 32'(PredTaken), 32'd0);
        chk("flush_ctr3", 32'(dut.u_bht.ctr[3]), 32'd2);
        chk("flush_perfmisp", 32'(PerfMisp), 32'd1);
        chk("flush_perfbr", 32'(PerfBr), 32'd3);
        step();
        EX_Branch = 1'b0;
        #1;
        chk("back_state", 32'(dut.state), 32'(RUN));
        chk("back_ctr3", 32'(dut.u_bht.ctr[3]), 32'd2);
        chk("back_perfbr", 32'(PerfBr), 32'd3);
        chk("back_perfmisp", 32'(PerfMisp), 32'd1);
        chk("back_pcsel", 32'(PCSel), 32'd1);
        EX_Taken = 1'b0; EX_PredTaken = 1'b0;
        #1;
        chk("recov_nt", RecoverPC, 32'h84);

        // Saturation at both ends
        IF_Branch = 1'b0;
        resolve(6'd7, 1'b0, 1'b0);
        chk("sat_ctr7_a", 32'(dut.u_bht.ctr[7]), 32'd0);
        for (int i = 0; i < 5; i++)
            resolve(6'd7, 1'b0, 1'b0);
        chk("sat_ctr7_b", 32'(dut.u_bht.ctr[7]), 32'd0);
        resolve(6'd16, 1'b1, 1'b1);
        chk("sat_ctr16", 32'(dut.u_bht.ctr[16]), 32'd3);
        chk("sat_perfbr10", 32'(PerfBr), 32'd10);

        // Resolve count up to and beyond 16'hFFFF
        EX_Branch = 1'b1; EX_Idx = 6'd8; EX_Taken = 1'b1; EX_PredTaken = 1'b1;
        for (int i = 0; i < 65524; i++)
            step();
        chk("perf_pre_sat", 32'(PerfBr), 32'hFFFE);
        step();
        chk("perf_at_sat", 32'(PerfBr), 32'hFFFF);
        for (int i = 0; i < 10; i++)
            step();
        EX_Branch = 1'b0;
        chk("perf_hold", 32'(PerfBr), 32'hFFFF);
        chk("perf_misp_hold", 32'(PerfMisp), 32'd1);

        // Same-index read/write: IF sees the old counter
        IF_PC = 32'h14; IF_Branch = 1'b1;
        EX_Branch = 1'b1; EX_Idx = 6'd5; EX_Taken = 1'b1; EX_PredTaken = 1'b1;
        #1;
        chk("coll_pred_old", 32'(PredTaken), 32'd0);
        chk("coll_pcsel_old", 32'(PCSel), 32'd0);
        step();
        EX_Branch = 1'b0;
        #1;
        chk("coll_pred_new", 32'(PredTaken), 32'd1);
        chk("coll_pcsel_new", 32'(PCSel), 32'd1);

        // Reset during FLUSH returns to RUN with clean counters
        EX_Branch = 1'b1; EX_Idx = 6'd9; EX_Taken = 1'b1; EX_PredTaken = 1'b0;
        step();
        chk("mid_flush_state", 32'(dut.state), 32'(FLUSH));
        Rst = 1'b0; EX_Branch = 1'b0;
        step();
        Rst = 1'b1;
        #1;
        chk("rst2_state", 32'(dut.state), 32'(RUN));
        chk("rst2_ctr5", 32'(dut.u_bht.ctr[5]), 32'd1);
        chk("rst2_perfbr", 32'(PerfBr), 32'd0);
        chk("rst2_perfmisp", 32'(PerfMisp), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/branch_predict_ctrl.md
# branch_predict_ctrl

Dynamic branch-prediction controller for the 5-stage MIPS pipeline; it replaces static not-taken handling of conditional branches. It indexes a table of 2-bit saturating counters with the IF-stage PC, steers the PC mux toward the predicted target, and resolves each branch in EX. On a mispredict it flushes wrong-path instructions and redirects to the recovery PC. It sits beside the hazard unit, which keeps ownership of load-use and jr stalls; mispredict redirect has priority over those stalls.

## Interface
- BHT_ENTRIES, 64, number of counters; power of two, 16..1024
- IDX_W, $clog2(BHT_ENTRIES), index width (derived)
- CTR_INIT, 2'b01, counter reset value (weakly not-taken)
- Clk  in  1  clock, rising edge
- Rst  in  1  reset, synchronous, active-low
- IF_PC  in  32  PC of the instruction in IF
- IF_Branch  in  1  predecode flag: the IF instruction is a conditional branch
- IF_BrTarget  in  32  predecoded branch target for the IF instruction
- Stall  in  1  hazard-unit freeze (PC_write=0)
- PredTaken  out  1  prediction for the IF instruction; piped to EX by the datapath
- PredIdx  out  IDX_W  table index used; piped to EX by the datapath
- EX_Branch  in  1  EX holds a valid conditional branch
- EX_Taken  in  1  resolved outcome (ALUZero)
- EX_PredTaken  in  1  PredTaken carried with the branch
- EX_Idx  in  IDX_W  PredIdx carried with the branch
- EX_PC  in  32  PC of the EX branch
- EX_Target  in  32  computed branch target in EX
- PCSel  out  2  00 PC+4, 01 IF_BrTarget, 10 RecoverPC
- RecoverPC  out  32  EX_Taken ? EX_Target : EX_PC+4
- Flush  out  1  squash IF/ID and ID/EX this cycle
- PerfBr  out  16  resolved-branch count, saturating
- PerfMisp  out  16  mispredict count, saturating

## Operation
- Prediction is combinational. idx = IF_PC[IDX_W+1:2]. PredTaken = IF_Branch & ctr[idx][1] & ~Stall & (state==RUN).
- Resolve: when EX_Branch=1 in RUN, ctr[EX_Idx] saturates up if EX_Taken=1 and down otherwise: 11 stays 11, 00 stays 00. PerfBr increments.
- Mispredict = EX_Branch & (EX_Taken != EX_PredTaken) & state==RUN.
  - Outputs: Flush=1, PCSel=10. PerfMisp increments.
  - Next state: FLUSH.
  - Mispredict overrides Stall and the current prediction.
- FSM states:
  - RUN: normal operation. Mispredict moves to FLUSH.
  - FLUSH: one cycle. EX_Branch is ignored because EX holds a bubble. Flush=0, PCSel=00, PredTaken=0. Always returns to RUN.
- PCSel priority: mispredict (10) > PredTaken (01) > 00.
- Stall:
  - Blocks prediction only.
  - EX resolution, table update and mispredict proceed normally.
- Read/write to the same index in one cycle: IF reads the old value. There is no bypass.
- Perf counters stop at 16'hFFFF.

## Timing
- Prediction latency 0: PredTaken, PredIdx and PCSel are valid in the same cycle as IF_PC.
- Mispredict detected in cycle N:
  - Flush and PCSel=10 are asserted in N.
  - Counter, PC and state update at edge N→N+1.
  - FLUSH occupies N+1; back in RUN at N+2.
  - Penalty is 2 cycles.
- Correct prediction: zero penalty, whether taken or not-taken.
- Reset (Rst=0 at an edge), including mid-FLUSH:
  - All counters ← CTR_INIT, state ← RUN, perf counters ← 0.
  - While Rst=0: PredTaken=0, Flush=0, PCSel=00, PredIdx=0. RecoverPC stays combinational.

## Configuration
- BP_GSHARE_EN defined:
  - Adds a global history register GHR[IDX_W-1:0], reset to 0.
  - On every RUN resolve: GHR ← {GHR[IDX_W-2:0], EX_Taken}.
  - IF index = IF_PC[IDX_W+1:2] ^ GHR. Updates use EX_Idx unchanged.
- Undefined: bimodal PC indexing only, and no GHR is instantiated.

## Structure
- Package bp_pkg holds:
  - Counter constants: SNT=00, WNT=01, WT=10, ST=11.
  - PCSel encodings: PCSEL_SEQ, PCSEL_PRED, PCSEL_RECOV.
  - State typedef: RUN, FLUSH.
- Sub-module bp_bht: counter array with one combinational read port, one synchronous saturating-update port, and synchronous reset to CTR_INIT.
- FSM, mispredict detect, GHR and perf counters live in branch_predict_ctrl.

## Test plan
- Reset: hold Rst=0 for 2 cycles, then release. Required: all counters 01, PredTaken=0, PerfBr=0, state RUN.
- Training: the same branch at PC 0x40 resolves taken twice.
  - ctr[16] goes 01→10→11.
  - The third fetch of 0x40 gives PredTaken=1 and PCSel=01.
- Mispredict: EX_PredTaken=0, EX_Taken=1, EX_Target=0x100.
  - Same cycle: Flush=1, PCSel=10, RecoverPC=0x100.
  - Next cycle: FLUSH state, and EX_Branch is ignored.
  - Cycle after that: RUN.
- Saturation: 5 not-taken resolves on a counter at 00 keep it at 00. PerfBr holds at FFFF after overflow.
- Same-index collision: IF reads index 5 while EX updates index 5 from 01 to 10. Required: PredTaken=0 that cycle and 1 on the next read.
- BP_GSHARE_EN build: after resolving taken, not-taken, taken (GHR=000101), IF_PC=0x40 indexes 16^5=21.
